alu_rr_sequencer: RTL and testbench

- Shares one combinational W_SIZE-bit ALU (3-bit op select, carry-in, result, carry/overflow, zero) between two requesters.
- Round-robin arbitration; registers the granted operands and op onto the ALU input ports, then captures the result and flags.
- Returns the result on a single tagged response channel with valid/ready handshakes.
- Sits between the instruction/control front-ends and the shared ALU instance.

---
 rtl/alu_rr_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_rr_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer that shares one external combinational ALU between two requesters.
// Optional per-requester carry chaining is enabled by defining ALU_RR_CARRY_CHAIN_EN.
module alu_rr_sequencer #(
  parameter int W_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [W_SIZE-1:0] req0_a,
  input  logic [W_SIZE-1:0] req0_b,
  input  logic              req0_use_c,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [W_SIZE-1:0] req1_a,
  input  logic [W_SIZE-1:0] req1_b,
  input  logic              req1_use_c,
  output logic [W_SIZE-1:0] alu_a,
  output logic [W_SIZE-1:0] alu_b,
  output logic [2:0]        alu_s,
  output logic              alu_cin,
  input  logic [W_SIZE-1:0] alu_res,
  input  logic              alu_of,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W_SIZE-1:0] rsp_result,
  output logic              rsp_of,
  output logic              rsp_zero,
  output logic              busy
);

  // Handshakes: a transfer occurs on a rising clk edge where valid and ready are both high.
  // reqN_ready is only raised in IDLE for the granted requester; rsp_* stay stable while rsp_valid waits for rsp_ready.
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t              state_q, state_d;
  logic                ptr_q;
  logic                gnt_id_q;
  logic                grant_any, grant_id;
  logic [2:0]          sel_op;
  logic [W_SIZE-1:0]   sel_a, sel_b;
  logic                sel_use_c, sel_cin;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE) begin
      grant_any = req0_valid | req1_valid;
      grant_id  = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    end
  end

  assign req0_ready = grant_any & ~grant_id;
  assign req1_ready = grant_any & grant_id;

  always_comb begin
    sel_op    = grant_id ? req1_op    : req0_op;
    sel_a     = grant_id ? req1_a     : req0_a;
    sel_b     = grant_id ? req1_b     : req0_b;
    sel_use_c = grant_id ? req1_use_c : req0_use_c;
  end

`ifdef ALU_RR_CARRY_CHAIN_EN
  logic [1:0] carry_q;

  assign sel_cin = (sel_op == 3'b000) & sel_use_c & carry_q[grant_id];

  // Only add/sub produce a meaningful carry, so only they update the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= '0;
    end else if (state_q == CAPT && (alu_s == 3'b000 || alu_s == 3'b001)) begin
      carry_q[gnt_id_q] <= alu_of;
    end
  end
`else
  logic unused_use_c;
  assign unused_use_c = sel_use_c;
  assign sel_cin      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant_any) state_d = EXEC;
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 1'b0;
      gnt_id_q   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      alu_cin    <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_of     <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      if (grant_any) begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_s    <= sel_op;
        alu_cin  <= sel_cin;
        gnt_id_q <= grant_id;
        ptr_q    <= ~grant_id;
      end
      if (state_q == CAPT) begin
        rsp_result <= alu_res;
        rsp_of     <= alu_of;
        rsp_zero   <= alu_zero;
        rsp_id     <= gnt_id_q;
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: behavioural ALU, accept-time scoreboard, latency and hold checks.
module tb_alu_rr_sequencer;
  localparam int W = 8;
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100, OP_NOT = 3'b101, OP_UND = 3'b111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_use_c = 1'b0, req1_use_c = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_s;
  logic         alu_cin, alu_of, alu_zero;
  logic         rsp_valid, rsp_id, rsp_of, rsp_zero, busy;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [W+2:0] exp_q[$];
  int           acc_q[$];
  logic         grant_log[$];
  logic [1:0]   carry_m = '0;
  logic         prev_valid;
  logic [W-1:0] last_res;
  logic         last_of, last_zero, last_id;

  alu_rr_sequencer #(.W_SIZE(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_use_c(req0_use_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_use_c(req1_use_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_res(alu_res), .alu_of(alu_of), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_of(rsp_of), .rsp_zero(rsp_zero), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU, returns {carry/overflow, zero, result}.
  function automatic logic [W+1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    logic [W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      default: r = '0;
    endcase
    return {r[W], (r[W-1:0] == '0), r[W-1:0]};
  endfunction

  assign {alu_of, alu_zero, alu_res} = alu_f(alu_s, alu_a, alu_b, alu_cin);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    carry_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // driver: hold the request until granted, then record the expected response
  task automatic issue(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic use_c);
    int n;
    logic got;
    logic cin;
    logic [W+1:0] r;
    n = 0;
    got = 1'b0;
    @(negedge clk);
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_use_c = use_c; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_use_c = use_c; req0_valid = 1'b1;
    end
    while (!got && n < 300) begin
      #1;
      if (id ? req1_ready : req0_ready) got = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!got) begin
      chk(id ? "accept_timeout_req1" : "accept_timeout_req0", 32'd0, 32'd1);
    end else begin
`ifdef ALU_RR_CARRY_CHAIN_EN
      cin = (op == OP_ADD) && use_c ? carry_m[id] : 1'b0;
`else
      cin = 1'b0;
`endif
      r = alu_f(op, a, b, cin);
      if (op == OP_ADD || op == OP_SUB) carry_m[id] = r[W+1];
      exp_q.push_back({id, r});
      acc_q.push_back(cyc);
      grant_log.push_back(id);
      @(posedge clk);
    end
    #1;
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic run1(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic use_c);
    issue(id, op, a, b, use_c);
    wait_drain();
  endtask

  // scoreboard / monitor
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (rsp_valid && !prev_valid) begin
        if (acc_q.size() > 0) begin
          chk("latency", 32'(cyc - acc_q[0]), 32'd3);
          void'(acc_q.pop_front());
        end else begin
          chk("valid_without_accept", 32'(rsp_valid), 32'd0);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rsp", 32'({rsp_id, rsp_of, rsp_zero, rsp_result}), 32'(e));
        end else begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end
        last_res  <= rsp_result;
        last_of   <= rsp_of;
        last_zero <= rsp_zero;
        last_id   <= rsp_id;
      end
      prev_valid <= rsp_valid;
    end
  end

  initial begin
    int n;
    logic [W+2:0] snap;

    @(negedge clk);
    chk("reset_alu", 32'({alu_a, alu_b, alu_s, alu_cin}), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_of, rsp_zero, busy, req0_ready, req1_ready}), 32'd0);
    rst_n = 1'b1;

    // reset asserted mid-EXEC aborts the operation
    issue(0, OP_ADD, 8'h11, 8'h22, 1'b0);
    chk("exec_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_alu", 32'({alu_a, alu_b, alu_s, alu_cin}), 32'd0);
    chk("midreset_rsp", 32'({rsp_valid, rsp_id, rsp_result, rsp_of, rsp_zero, busy, req0_ready, req1_ready}), 32'd0);
    do_reset();

    run1(0, OP_ADD, 8'd3, 8'd4, 1'b0);
    chk("add_3_4", 32'({last_id, last_of, last_zero, last_res}), 32'({1'b0, 1'b0, 1'b0, 8'd7}));
    chk("alu_hold", 32'({alu_a, alu_b, alu_s}), 32'({8'd3, 8'd4, OP_ADD}));

    // flags and op coverage
    run1(0, OP_ADD, 8'hFF, 8'h01, 1'b0);
    chk("ff_plus_1", 32'({last_of, last_zero, last_res}), 32'({1'b1, 1'b1, 8'h00}));
    run1(1, OP_XOR, 8'h0F, 8'h0F, 1'b0);
    chk("xor_zero", 32'({last_id, last_of, last_zero, last_res}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
    run1(0, OP_NOT, 8'hA5, 8'h00, 1'b0);
    chk("not_a5", 32'({last_of, last_zero, last_res}), 32'({1'b0, 1'b0, 8'h5A}));
    run1(1, OP_UND, 8'h12, 8'h34, 1'b0);
    chk("undef_op", 32'({last_id, last_of, last_zero, last_res}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
    run1(0, OP_SUB, 8'h05, 8'h07, 1'b0);
    chk("sub_borrow", 32'({last_of, last_zero, last_res}), 32'({1'b1, 1'b0, 8'hFE}));

    // carry chain per requester
    run1(1, OP_ADD, 8'h00, 8'h00, 1'b0);
    run1(0, OP_ADD, 8'hFF, 8'h01, 1'b0);
    run1(1, OP_ADD, 8'h00, 8'h00, 1'b1);
    chk("chain_req1_isolated", 32'(last_res), 32'd0);
    run1(0, OP_ADD, 8'h00, 8'h00, 1'b1);
`ifdef ALU_RR_CARRY_CHAIN_EN
    chk("chain_req0", 32'(last_res), 32'h01);
`else
    chk("chain_req0", 32'(last_res), 32'h00);
`endif

    // backpressure: response held, no new grant until handshake
    rsp_ready = 1'b0;
    issue(0, OP_OR, 8'h30, 8'h0C, 1'b0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_payload", 32'({rsp_id, rsp_of, rsp_zero, rsp_result}), 32'({1'b0, 1'b0, 1'b0, 8'h3C}));
    snap = {rsp_id, rsp_of, rsp_zero, rsp_result};
    fork
      issue(1, OP_AND, 8'hF0, 8'h3C, 1'b0);
    join_none
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold", 32'({rsp_id, rsp_of, rsp_zero, rsp_result}), 32'(snap));
      chk("bp_readies", 32'({rsp_valid, req0_ready, req1_ready}), 32'b100);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait fork;
    wait_drain();
    chk("bp_new_grant", 32'(grant_log[$]), 32'd1);
    chk("bp_and", 32'(last_res), 32'h30);

    // round robin with both requesters continuously valid
    do_reset();
    grant_log.delete();
    fork
      for (int i = 0; i < 4; i++)
        issue(0, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      for (int j = 0; j < 4; j++)
        issue(1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
    join
    wait_drain();
    chk("rr_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size(); k++) chk("rr_order", 32'(grant_log[k]), 32'(k % 2));

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
